// File: rtl/tisc_pkg.sv
// Shared register map, STATUS/CFG field positions and SPI FSM state type
// for the TISC control/SPI slave.
package tisc_pkg;

    localparam logic [3:0] REG_IDENT   = 4'd0;
    localparam logic [3:0] REG_VERSION = 4'd1;
    localparam logic [3:0] REG_CTRL    = 4'd2;
    localparam logic [3:0] REG_CS      = 4'd3;
    localparam logic [3:0] REG_CFG     = 4'd4;
    localparam logic [3:0] REG_DATA    = 4'd5;
    localparam logic [3:0] REG_STATUS  = 4'd6;
    localparam logic [3:0] REG_SCRATCH = 4'd7;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    localparam int CFG_DIV_LSB = 0;
    localparam int CFG_DIV_MSB = 7;
    localparam int CFG_CPOL    = 8;
    localparam int CFG_CPHA    = 9;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/tisc_spi_engine.sv
// SPI byte shift engine: SCK divider, edge counter, tx/rx shift registers and
// IDLE/SHIFT FSM. All four CPOL/CPHA modes, MSB first, 16 SCK edges per byte.
module tisc_spi_engine
    import tisc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_tx,
    input  logic [7:0] i_div,
    input  logic       i_cpol,
    input  logic       i_cpha,
    input  logic       i_miso,
    output logic       o_busy,
    output logic       o_done_pulse,
    output logic       o_sck,
    output logic       o_mosi,
    output logic [7:0] o_rx
);

    spi_state_t r_state;
    spi_state_t w_next_state;

    logic [7:0] r_div;
    logic       r_cpha;
    logic [7:0] r_div_cnt;
    logic [3:0] r_edge;
    logic [7:0] r_tx_sh;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx;
    logic       r_sck;
    logic       r_mosi;

    logic w_tick;
    logic w_last;
    logic w_odd;
    logic w_sample;
    logic w_shift;

    // r_edge counts edges already made, so the upcoming edge number is r_edge+1
    assign w_tick   = (r_state == SPI_SHIFT) && (r_div_cnt == r_div);
    assign w_last   = w_tick && (r_edge == 4'd15);
    assign w_odd    = ~r_edge[0];
    assign w_sample = w_tick && (r_cpha ? ~w_odd : w_odd);
    assign w_shift  = w_tick && (r_cpha ? w_odd : (~w_odd && !w_last));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= SPI_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SPI_IDLE:  if (i_start) w_next_state = SPI_SHIFT;
            SPI_SHIFT: if (w_last)  w_next_state = SPI_IDLE;
            default:   w_next_state = SPI_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state == SPI_SHIFT);
        o_done_pulse = w_last;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div     <= 8'd0;
            r_cpha    <= 1'b0;
            r_div_cnt <= 8'd0;
            r_edge    <= 4'd0;
            r_tx_sh   <= 8'd0;
            r_rx_sh   <= 8'd0;
            r_rx      <= 8'd0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else if (r_state == SPI_IDLE) begin
            r_sck     <= i_cpol;
            r_div_cnt <= 8'd0;
            r_edge    <= 4'd0;
            if (i_start) begin
                r_div   <= i_div;
                r_cpha  <= i_cpha;
                r_rx_sh <= 8'd0;
                // CPHA=0 presents bit 7 immediately; CPHA=1 waits for edge 1
                if (i_cpha) begin
                    r_tx_sh <= i_tx;
                end else begin
                    r_tx_sh <= {i_tx[6:0], 1'b0};
                    r_mosi  <= i_tx[7];
                end
            end
        end else begin
            if (w_tick) begin
                r_div_cnt <= 8'd0;
                r_sck     <= ~r_sck;
                r_edge    <= r_edge + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
            if (w_shift) begin
                r_mosi  <= r_tx_sh[7];
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
            if (w_sample) r_rx_sh <= {r_rx_sh[6:0], i_miso};
            if (w_last)   r_rx    <= r_cpha ? {r_rx_sh[6:0], i_miso} : r_rx_sh;
        end
    end

    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

endmodule

// File: rtl/tisc_ctrl_spi_v2.sv
// TISC identification/control/SPI-master slave on a 64-byte WISHBONE classic
// window: bus decode, registers, STATUS sticky bits and reset synchroniser.
module tisc_ctrl_spi_v2
    import tisc_pkg::*;
#(
    parameter logic [31:0]      IDENT      = 32'h54534332,
    parameter logic [31:0]      VERSION    = 32'h0,
    parameter int               NCTRL      = 2,
    parameter logic [NCTRL-1:0] CTRL_RESET = 2'b11,
    parameter int               NCS        = 1,
    parameter logic [7:0]       DIV_RESET  = 8'd3
)(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [5:0]       adr_i,
    input  logic [31:0]      dat_i,
    input  logic [3:0]       sel_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             rty_o,
    output logic [NCTRL-1:0] ctrl_o,
    output logic [NCS-1:0]   CS_B,
    output logic             SCK,
    output logic             MOSI,
    input  logic             MISO
);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic [NCTRL-1:0] r_ctrl;
    logic [NCS-1:0]   r_cs;
    logic [7:0]       r_div;
    logic             r_cpol;
    logic             r_cpha;
    logic             r_done;
    logic             r_ovr;
    logic [31:0]      r_scratch;

    logic        w_req;
    logic        w_wr;
    logic [3:0]  w_word;
    logic        w_data_wr;
    logic        w_status_wr;
    logic        w_start;
    logic        w_busy;
    logic        w_done_pulse;
    logic [7:0]  w_rx;
    logic [31:0] w_rd_data;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_cs_rd;
    logic        w_unused;

    // Assertion reaches every flop asynchronously; release waits two clocks
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_req       = cyc_i & stb_i & ~r_ack;
    assign w_wr        = w_req & we_i;
    assign w_word      = adr_i[5:2];
    assign w_data_wr   = w_wr && (w_word == REG_DATA);
    assign w_status_wr = w_wr && (w_word == REG_STATUS);
    assign w_start     = w_data_wr && !w_busy;

    tisc_spi_engine u_spi (
        .i_clk        (clk_i),
        .i_rst_n      (w_rst_n),
        .i_start      (w_start),
        .i_tx         (dat_i[7:0]),
        .i_div        (r_div),
        .i_cpol       (r_cpol),
        .i_cpha       (r_cpha),
        .i_miso       (MISO),
        .o_busy       (w_busy),
        .o_done_pulse (w_done_pulse),
        .o_sck        (SCK),
        .o_mosi       (MOSI),
        .o_rx         (w_rx)
    );

    always_comb begin
        w_ctrl_rd = 32'd0;
        w_ctrl_rd[NCTRL-1:0] = r_ctrl;
        w_cs_rd = 32'd0;
        w_cs_rd[NCS-1:0] = r_cs;
        w_rd_data = 32'd0;
        case (w_word)
            REG_IDENT:   w_rd_data = IDENT;
            REG_VERSION: w_rd_data = VERSION;
            REG_CTRL:    w_rd_data = w_ctrl_rd;
            REG_CS:      w_rd_data = w_cs_rd;
            REG_CFG:     w_rd_data = {22'd0, r_cpha, r_cpol, r_div};
            REG_DATA:    w_rd_data = {24'd0, w_rx};
            REG_STATUS:  w_rd_data = {29'd0, r_ovr, r_done, w_busy};
            REG_SCRATCH: w_rd_data = r_scratch;
            default:     w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
            r_ctrl    <= CTRL_RESET;
            r_cs      <= '0;
            r_div     <= DIV_RESET;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_scratch <= 32'd0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rd_data;
            if (w_wr) begin
                case (w_word)
                    REG_CTRL:    r_ctrl    <= dat_i[NCTRL-1:0];
                    REG_CS:      r_cs      <= dat_i[NCS-1:0];
                    REG_CFG: begin
                        r_div  <= dat_i[CFG_DIV_MSB:CFG_DIV_LSB];
                        r_cpol <= dat_i[CFG_CPOL];
                        r_cpha <= dat_i[CFG_CPHA];
                    end
                    REG_SCRATCH: r_scratch <= dat_i;
                    default: ;
                endcase
            end
        end
    end

    // Sticky bits: a set on the same edge as a write-1 clear wins
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_done <= w_done_pulse | (r_done & ~(w_status_wr & dat_i[ST_DONE]));
            r_ovr  <= (w_data_wr & w_busy) | (r_ovr & ~(w_status_wr & dat_i[ST_OVR]));
        end
    end

    assign dat_o    = r_dat;
    assign ack_o    = r_ack;
    assign err_o    = 1'b0;
    assign rty_o    = 1'b0;
    assign ctrl_o   = r_ctrl;
    assign CS_B     = ~r_cs;
    assign w_unused = &{1'b0, sel_i, adr_i[1:0]};

endmodule

// File: tb/tb_tisc_ctrl_spi_v2.sv
// Directed bench for tisc_ctrl_spi_v2: register map, SPI modes 0/3, overrun
// and asynchronous reset mid-transfer, with hand-computed expectations.
`timescale 1ns/100ps
module tb_tisc_ctrl_spi_v2;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [5:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        ack, err, rty;
    logic [1:0]  ctrl;
    logic [0:0]  cs_b;
    logic        sck, mosi, miso;
    logic        loop_en;
    logic        miso_v;

    int total = 0;
    int bad   = 0;

    assign miso = loop_en ? mosi : miso_v;

    tisc_ctrl_spi_v2 dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .dat_i   (wdat),
        .sel_i   (sel),
        .dat_o   (rdat),
        .ack_o   (ack),
        .err_o   (err),
        .rty_o   (rty),
        .ctrl_o  (ctrl),
        .CS_B    (cs_b),
        .SCK     (sck),
        .MOSI    (mosi),
        .MISO    (miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [5:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 4);
        chk("ack", {31'd0, ack}, 32'd1);
        rd = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb(1'b0, a, 32'd0, v);
        chk(tag, v, exp);
    endtask

    // Start a byte and count busy cycles and SCK rising edges until it ends
    task automatic xfer(input logic [7:0] b, output int busy_cnt, output int rises);
        logic prev;
        wr(6'd20, {24'd0, b});
        busy_cnt = 0;
        rises = 0;
        prev = sck;
        while (dut.u_spi.o_busy && busy_cnt < 1000) begin
            busy_cnt++;
            @(posedge clk); #1;
            if (sck && !prev) rises++;
            prev = sck;
        end
        chk("busy_end", {31'd0, dut.u_spi.o_busy}, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (dut.u_spi.o_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", {31'd0, dut.u_spi.o_busy}, 32'd0);
    endtask

    initial begin
        int bc, sr;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 6'd0; wdat = 32'd0; sel = 4'hF; loop_en = 1'b0; miso_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  {31'd0, ack}, 32'd0);
        chk("rst_dat",  rdat, 32'd0);
        chk("rst_ctrl", {30'd0, ctrl}, 32'd3);
        chk("rst_csb",  {31'd0, cs_b}, 32'd1);
        chk("rst_sck",  {31'd0, sck}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        rd_chk("ident",   6'd0,  32'h54534332);
        rd_chk("version", 6'd4,  32'h0);
        rd_chk("ctrl0",   6'd8,  32'h3);
        rd_chk("cs0",     6'd12, 32'h0);
        rd_chk("cfg0",    6'd16, 32'h3);
        chk("errrty", {30'd0, err, rty}, 32'd0);

        wr(6'd8, 32'h1);
        chk("ctrl_o_edge", {30'd0, ctrl}, 32'd1);
        wr(6'd28, 32'hDEADBEEF);
        rd_chk("ctrl_rb", 6'd8, 32'h1);
        rd_chk("scratch", 6'd28, 32'hDEADBEEF);
        wr(6'd36, 32'h12345678);
        rd_chk("word9", 6'd36, 32'h0);
        wr(6'd12, 32'h1);
        chk("csb_low", {31'd0, cs_b}, 32'd0);
        wr(6'd12, 32'h0);
        chk("csb_high", {31'd0, cs_b}, 32'd1);

        // Mode 0, DIV=1, loopback
        wr(6'd16, 32'h001);
        loop_en = 1'b1;
        xfer(8'hA5, bc, sr);
        chk("m0_busy", bc, 32);
        chk("m0_rises", sr, 8);
        rd_chk("m0_data", 6'd20, 32'hA5);
        rd_chk("m0_stat", 6'd24, 32'h2);
        wr(6'd24, 32'h2);
        rd_chk("m0_clr", 6'd24, 32'h0);

        // Mode 3, DIV=0, MISO tied high
        wr(6'd16, 32'h300);
        loop_en = 1'b0; miso_v = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("m3_idle_sck", {31'd0, sck}, 32'd1);
        xfer(8'h3C, bc, sr);
        chk("m3_busy", bc, 16);
        chk("m3_end_sck", {31'd0, sck}, 32'd1);
        rd_chk("m3_data", 6'd20, 32'hFF);
        wr(6'd24, 32'h2);

        // Overrun: second DATA write 5 cycles into a mode 0 transfer
        wr(6'd16, 32'h001);
        loop_en = 1'b1;
        wr(6'd20, 32'h5A);
        repeat (3) @(posedge clk);
        #1;
        wr(6'd20, 32'h81);
        wait_idle();
        rd_chk("ovr_data", 6'd20, 32'h5A);
        rd_chk("ovr_stat", 6'd24, 32'h6);
        wr(6'd24, 32'h6);
        rd_chk("ovr_clr", 6'd24, 32'h0);

        // Asynchronous reset pulse mid-transfer, between clock edges
        wr(6'd12, 32'h1);
        wr(6'd20, 32'hC3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk("ar_sck",  {31'd0, sck}, 32'd0);
        chk("ar_busy", {31'd0, dut.u_spi.o_busy}, 32'd0);
        chk("ar_csb",  {31'd0, cs_b}, 32'd1);
        chk("ar_ctrl", {30'd0, ctrl}, 32'd3);
        #0.5;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("ar_cfg",  6'd16, 32'h3);
        rd_chk("ar_stat", 6'd24, 32'h0);
        xfer(8'h96, bc, sr);
        chk("ar_busy_len", bc, 64);
        rd_chk("ar_data", 6'd20, 32'h96);
        rd_chk("ar_done", 6'd24, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
